// File: rtl/sync_gray2bin.sv
// Receive-side Gray-code synchronizer: samples an asynchronous Gray bus,
// decodes it to binary, and reports change strobes, step size and step errors.
module sync_gray2bin #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] gray_in,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] bin_out,
    output logic                  bin_valid,
    output logic                  changed,
    output logic [DATA_WIDTH-1:0] delta,
    output logic                  step_error
);

    localparam int               CNT_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [DATA_WIDTH-1:0] DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [DATA_WIDTH-1:0] gray_to_bin(input logic [DATA_WIDTH-1:0] g);
        logic [DATA_WIDTH-1:0] b;
        b[DATA_WIDTH-1] = g[DATA_WIDTH-1];
        for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    function automatic logic multi_bit(input logic [DATA_WIDTH-1:0] x);
        return (x & (x - DATA_ONE)) != {DATA_WIDTH{1'b0}};
    endfunction

    logic [DATA_WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] g_prev_r;
    logic [DATA_WIDTH-1:0] bin_r;
    logic [DATA_WIDTH-1:0] delta_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  valid_r;
    logic                  changed_r;
    logic                  err_r;

    logic [DATA_WIDTH-1:0] g_s;
    logic [DATA_WIDTH-1:0] decoded_s;
    logic                  multi_s;

    // Decode the synchronized Gray value and detect multi-bit steps.
    always_comb begin
        g_s       = sync_r[SYNC_STAGES-1];
        decoded_s = gray_to_bin(g_s);
        multi_s   = multi_bit(g_s ^ g_prev_r);
    end

    // Synchronizer chain, decode register, warm-up counter and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= {DATA_WIDTH{1'b0}};
            end
            g_prev_r  <= {DATA_WIDTH{1'b0}};
            bin_r     <= {DATA_WIDTH{1'b0}};
            delta_r   <= {DATA_WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            valid_r   <= 1'b0;
            changed_r <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            sync_r[0] <= gray_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
            g_prev_r <= g_s;
            bin_r    <= decoded_s;

            if (cnt_r != CNT_FULL) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
            // Valid one edge after the count saturates, when bin_r holds the first real sample.
            valid_r <= (cnt_r == CNT_FULL);

            if (valid_r && (decoded_s != bin_r)) begin
                changed_r <= 1'b1;
                delta_r   <= decoded_s - bin_r;
            end else begin
                changed_r <= 1'b0;
                delta_r   <= delta_r;
            end

            // A new violation outranks a simultaneous clear.
            if (valid_r && multi_s) begin
                err_r <= 1'b1;
            end else if (err_clr) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign bin_out    = bin_r;
    assign bin_valid  = valid_r;
    assign changed    = changed_r;
    assign delta      = delta_r;
    assign step_error = err_r;

endmodule

// File: tb/tb_sync_gray2bin.sv
// Bench for sync_gray2bin: constant-table vectors, hand-written latency/priority
// sequences and randomized traffic against a sample-history reference model.
module tb_sync_gray2bin;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] gray_in;
    logic         err_clr;
    logic [W-1:0] bin_out;
    logic         bin_valid;
    logic         changed;
    logic [W-1:0] delta;
    logic         step_error;

    sync_gray2bin #(.DATA_WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gray_in    (gray_in),
        .err_clr    (err_clr),
        .bin_out    (bin_out),
        .bin_valid  (bin_valid),
        .changed    (changed),
        .delta      (delta),
        .step_error (step_error)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: history of samples taken at each edge since reset.
    logic [W-1:0] hist[$];
    int           k_edges;
    logic [W-1:0] m_bin;
    logic         m_valid;
    logic         m_changed;
    logic [W-1:0] m_delta;
    logic         m_err;

    typedef struct {
        logic [W-1:0] gray;
        logic         clr;
        logic [W-1:0] bin;
        logic [W-1:0] dlt;
        logic         err;
        int           pulses;
    } vec_t;

    vec_t tbl[11];

    function automatic logic [W-1:0] ref_bin(input logic [W-1:0] g);
        logic [W-1:0] b = '0;
        for (int i = 0; i < W; i++) b = b ^ (g >> i);
        return b;
    endfunction

    function automatic logic [W-1:0] to_gray(input logic [W-1:0] x);
        return x ^ (x >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        k_edges   = 0;
        m_bin     = '0;
        m_valid   = 1'b0;
        m_changed = 1'b0;
        m_delta   = '0;
        m_err     = 1'b0;
    endtask

    task automatic model_step();
        logic [W-1:0] nb;
        logic         pv;
        if (!rst_n) begin
            model_reset();
            return;
        end
        k_edges++;
        hist.push_back(gray_in);
        nb = (k_edges >= S + 1) ? ref_bin(hist[k_edges-S-1]) : '0;
        pv = m_valid;
        m_valid = (k_edges >= S + 1);
        if (pv && nb != m_bin) begin
            m_changed = 1'b1;
            m_delta   = nb - m_bin;
        end else begin
            m_changed = 1'b0;
        end
        if (pv && $countones(hist[k_edges-S-1] ^ hist[k_edges-S-2]) > 1) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        m_bin = nb;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".bin_out"},    bin_out,    m_bin);
        check({tag, ".bin_valid"},  bin_valid,  m_valid);
        check({tag, ".changed"},    changed,    m_changed);
        check({tag, ".delta"},      delta,      m_delta);
        check({tag, ".step_error"}, step_error, m_err);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all("model");
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst.bin_out", bin_out, 32'h0);
        check("async_rst.valid", bin_valid, 32'h0);
        check("async_rst.err", step_error, 32'h0);
        compare_all("async_rst");
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int pulses;
        int rel;
        logic [W-1:0] rc;
        int r;

        tbl[0]  = '{8'h03, 1'b0, 8'h02, 8'h02, 1'b1, 1};
        tbl[1]  = '{8'h03, 1'b1, 8'h02, 8'h02, 1'b0, 0};
        tbl[2]  = '{8'h02, 1'b0, 8'h03, 8'h01, 1'b0, 1};
        tbl[3]  = '{8'h06, 1'b0, 8'h04, 8'h01, 1'b0, 1};
        tbl[4]  = '{8'h07, 1'b0, 8'h05, 8'h01, 1'b0, 1};
        tbl[5]  = '{8'h05, 1'b0, 8'h06, 8'h01, 1'b0, 1};
        tbl[6]  = '{8'h04, 1'b0, 8'h07, 8'h01, 1'b0, 1};
        tbl[7]  = '{8'h0C, 1'b0, 8'h08, 8'h01, 1'b0, 1};
        tbl[8]  = '{8'h80, 1'b0, 8'hFF, 8'hF7, 1'b1, 1};
        tbl[9]  = '{8'h80, 1'b1, 8'hFF, 8'hF7, 1'b0, 0};
        tbl[10] = '{8'h00, 1'b0, 8'h00, 8'h01, 1'b0, 1};

        rst_n   = 1'b1;
        gray_in = 8'h00;
        err_clr = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Warm-up: valid on the third edge after release, no changed pulse.
        tick();
        check("warmup.e1.valid", bin_valid, 32'h0);
        tick();
        check("warmup.e2.valid", bin_valid, 32'h0);
        tick();
        check("warmup.e3.valid", bin_valid, 32'h1);
        check("warmup.e3.changed", changed, 32'h0);
        check("warmup.e3.bin", bin_out, 32'h0);
        tick();
        tick();

        foreach (tbl[i]) begin
            gray_in = tbl[i].gray;
            err_clr = tbl[i].clr;
            pulses  = 0;
            repeat (4) begin
                tick();
                if (changed) pulses++;
            end
            err_clr = 1'b0;
            check($sformatf("tbl%0d.bin", i), bin_out, tbl[i].bin);
            check($sformatf("tbl%0d.delta", i), delta, tbl[i].dlt);
            check($sformatf("tbl%0d.err", i), step_error, tbl[i].err);
            check($sformatf("tbl%0d.pulses", i), pulses, tbl[i].pulses);
        end

        // Exact latency of a single step 0x06 -> 0x07.
        gray_in = 8'h06;
        repeat (4) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        gray_in = 8'h07;
        tick();
        check("lat.e0.bin", bin_out, 32'h04);
        check("lat.e0.changed", changed, 32'h0);
        tick();
        check("lat.e1.bin", bin_out, 32'h04);
        tick();
        check("lat.e2.bin", bin_out, 32'h05);
        check("lat.e2.changed", changed, 32'h1);
        check("lat.e2.delta", delta, 32'h01);
        check("lat.e2.err", step_error, 32'h0);
        tick();
        check("lat.e3.changed", changed, 32'h0);

        // Multi-bit jump is sticky.
        gray_in = 8'h00;
        repeat (4) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        gray_in = 8'h03;
        repeat (3) tick();
        check("jump.bin", bin_out, 32'h02);
        check("jump.delta", delta, 32'h02);
        check("jump.err", step_error, 32'h1);
        repeat (10) tick();
        check("jump.sticky", step_error, 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr.err", step_error, 32'h0);

        // Clear and a new violation on the same edge: set wins.
        gray_in = 8'h01;
        repeat (3) tick();
        gray_in = 8'h00;
        repeat (3) tick();
        check("prio.pre_err", step_error, 32'h0);
        gray_in = 8'h05;
        tick();
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("prio.err", step_error, 32'h1);
        check("prio.bin", bin_out, 32'h06);
        check("prio.delta", delta, 32'h06);
        check("prio.changed", changed, 32'h1);

        // Reset mid-stream while counting 0..20 one step per cycle.
        rel = -1;
        for (int i = 0; i <= 20; i++) begin
            gray_in = to_gray(8'(i));
            tick();
            if (rel >= 0) begin
                rel++;
                if (rel == 2) check("midrst.e2.valid", bin_valid, 32'h0);
                if (rel == 3) begin
                    check("midrst.e3.valid", bin_valid, 32'h1);
                    check("midrst.e3.changed", changed, 32'h0);
                end
                if (rel == 4) check("midrst.e4.changed", changed, 32'h1);
            end
            if (i == 10) begin
                async_reset();
                rel = 0;
            end
        end

        // Randomized traffic: mostly legal Gray steps, some jumps, random clears and resets.
        rc = 8'($urandom);
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 70) rc = rc + (($urandom_range(0, 1) == 1) ? 8'h01 : 8'hFF);
            else if (r < 90) rc = 8'($urandom);
            gray_in = to_gray(rc);
            err_clr = ($urandom_range(0, 7) == 0);
            if (r == 99) async_reset();
            tick();
        end
        err_clr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
